// File: rtl/waveform_word_buffer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// waveform_word_buffer_pkg : shared FSM encodings and half-word split helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
package waveform_word_buffer_pkg;

  typedef enum logic [2:0] {
    R_IDLE   = 3'd0,
    R_REQ_LO = 3'd1,
    R_REQ_HI = 3'd2,
    R_GAP    = 3'd3,
    R_DONE   = 3'd4
  } refresh_state_t;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_FETCH   = 2'd1,
    RD_PRESENT = 2'd2
  } read_state_t;

  // A DAC word is built from one full RAM read plus the low bits of a second.
  function automatic int lo_half_wid(input int word_wid, input int ram_word_wid);
    return (ram_word_wid < word_wid) ? ram_word_wid : word_wid;
  endfunction

  function automatic int hi_half_wid(input int word_wid, input int ram_word_wid);
    return word_wid - lo_half_wid(word_wid, ram_word_wid);
  endfunction

endpackage
`default_nettype wire

// File: rtl/waveform_word_buffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// waveform_word_buffer_if : sequencer word handshake and DMA read bus
// Revision: 1.0
// ---------------------------------------------------------------------------
interface waveform_word_buffer_if #(
  parameter int WORD_WID     = 20,
  parameter int RAM_WID      = 32,
  parameter int RAM_WORD_WID = 16
);
  logic                    word_rst;
  logic                    word_next;
  logic [WORD_WID-1:0]     word;
  logic                    word_ok;
  logic                    word_last;
  logic                    refresh_start;
  logic [RAM_WID-1:0]      start_addr;
  logic                    refresh_finished;
  logic [RAM_WID-1:0]      ram_dma_addr;
  logic [RAM_WORD_WID-1:0] ram_word;
  logic                    ram_read;
  logic                    ram_valid;

  modport master (
    output word_rst, word_next, refresh_start, start_addr, ram_word, ram_valid,
    input  word, word_ok, word_last, refresh_finished, ram_dma_addr, ram_read
  );

  modport slave (
    input  word_rst, word_next, refresh_start, start_addr, ram_word, ram_valid,
    output word, word_ok, word_last, refresh_finished, ram_dma_addr, ram_read
  );
endinterface
`default_nettype wire

// File: rtl/waveform_word_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// waveform_word_ram : simple dual-port RAM, registered 1-cycle read port
// Revision: 1.0
// ---------------------------------------------------------------------------
module waveform_word_ram #(
  parameter int DEPTH = 2047,
  parameter int WID   = 20,
  parameter int AWID  = 11
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AWID-1:0] wr_addr,
  input  logic [WID-1:0]  wr_data,
  input  logic            rd_en,
  input  logic [AWID-1:0] rd_addr,
  output logic [WID-1:0]  rd_data
);
  logic [WID-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= r_mem[rd_addr];
    end
  end
endmodule
`default_nettype wire

// File: rtl/waveform_word_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// waveform_word_buffer : DMA-loads a DAC word table and serves it word by word
// Revision: 1.0
// ---------------------------------------------------------------------------
module waveform_word_buffer
  import waveform_word_buffer_pkg::*;
#(
  parameter int WORD_WID      = 20,
  parameter int WORD_AMNT_WID = 11,
  parameter int WORD_AMNT     = 2047,
  parameter int RAM_WID       = 32,
  parameter int RAM_WORD_WID  = 16,
  parameter int RAM_WORD_INCR = 2
) (
  input logic                  clk,
  input logic                  rst_L,
  waveform_word_buffer_if.slave bus
);
  localparam int C_LO_WID = lo_half_wid(WORD_WID, RAM_WORD_WID);
  localparam int C_HI_WID = hi_half_wid(WORD_WID, RAM_WORD_WID);
  localparam logic [WORD_AMNT_WID-1:0] C_LAST_IDX = WORD_AMNT_WID'(WORD_AMNT - 1);
  localparam logic [RAM_WID-1:0]       C_INCR     = RAM_WID'(RAM_WORD_INCR);

  refresh_state_t          r_rstate;
  logic [RAM_WID-1:0]      r_addr;
  logic [WORD_AMNT_WID-1:0] r_windex;
  logic [C_LO_WID-1:0]     r_lo;
  logic [C_HI_WID-1:0]     r_hi;
  logic                    r_lo_done;
  logic                    r_ram_read;
  logic                    r_finished;

  read_state_t             r_rdstate;
  logic [WORD_AMNT_WID-1:0] r_ptr;
  logic [WORD_WID-1:0]     r_word;
  logic                    r_word_ok;
  logic                    r_word_last;

  logic                    w_wr_en;
  logic [WORD_WID-1:0]     w_wr_data;
  logic                    w_rd_en;
  logic [WORD_WID-1:0]     w_rd_data;

  // Refresh: lo read, gap, hi read, gap (word written here), repeat.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      r_rstate   <= R_IDLE;
      r_addr     <= '0;
      r_windex   <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_lo_done  <= 1'b0;
      r_ram_read <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (bus.refresh_start && bus.word_rst) begin
            r_addr     <= bus.start_addr;
            r_windex   <= '0;
            r_lo_done  <= 1'b0;
            r_ram_read <= 1'b1;
            r_rstate   <= R_REQ_LO;
          end
        end
        R_REQ_LO: begin
          if (bus.ram_valid) begin
            r_lo       <= C_LO_WID'(bus.ram_word);
            r_lo_done  <= 1'b1;
            r_addr     <= r_addr + C_INCR;
            r_ram_read <= 1'b0;
            r_rstate   <= R_GAP;
          end
        end
        R_REQ_HI: begin
          if (bus.ram_valid) begin
            r_hi       <= C_HI_WID'(bus.ram_word);
            r_lo_done  <= 1'b0;
            r_addr     <= r_addr + C_INCR;
            r_ram_read <= 1'b0;
            r_rstate   <= R_GAP;
          end
        end
        R_GAP: begin
          if (r_lo_done) begin
            r_ram_read <= 1'b1;
            r_rstate   <= R_REQ_HI;
          end else if (r_windex == C_LAST_IDX) begin
            r_finished <= 1'b1;
            r_rstate   <= R_DONE;
          end else begin
            r_windex   <= r_windex + 1'b1;
            r_ram_read <= 1'b1;
            r_rstate   <= R_REQ_LO;
          end
        end
        R_DONE: begin
          if (!bus.refresh_start) begin
            r_finished <= 1'b0;
            r_rstate   <= R_IDLE;
          end
        end
        default: begin
          r_ram_read <= 1'b0;
          r_finished <= 1'b0;
          r_rstate   <= R_IDLE;
        end
      endcase
    end
  end

  assign w_wr_en   = rst_L && (r_rstate == R_GAP) && !r_lo_done;
  assign w_wr_data = {r_hi, r_lo};
  assign w_rd_en   = rst_L && !bus.word_rst && bus.word_next &&
                     (r_rdstate == RD_IDLE) && (r_rstate == R_IDLE);

  // Read side: issue buffer read, take RAM output next cycle, hold until release.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      r_rdstate   <= RD_IDLE;
      r_ptr       <= '0;
      r_word      <= '0;
      r_word_ok   <= 1'b0;
      r_word_last <= 1'b0;
    end else if (bus.word_rst) begin
      r_rdstate   <= RD_IDLE;
      r_ptr       <= '0;
      r_word_ok   <= 1'b0;
      r_word_last <= 1'b0;
    end else begin
      case (r_rdstate)
        RD_IDLE: begin
          if (w_rd_en) begin
            r_rdstate <= RD_FETCH;
          end
        end
        RD_FETCH: begin
          r_word      <= w_rd_data;
          r_word_ok   <= 1'b1;
          r_word_last <= (r_ptr == C_LAST_IDX);
          r_rdstate   <= RD_PRESENT;
        end
        RD_PRESENT: begin
          if (!bus.word_next) begin
            r_word_ok   <= 1'b0;
            r_word_last <= 1'b0;
            r_ptr       <= (r_ptr == C_LAST_IDX) ? '0 : r_ptr + 1'b1;
            r_rdstate   <= RD_IDLE;
          end
        end
        default: begin
          r_word_ok   <= 1'b0;
          r_word_last <= 1'b0;
          r_rdstate   <= RD_IDLE;
        end
      endcase
    end
  end

  waveform_word_ram #(
    .DEPTH (WORD_AMNT),
    .WID   (WORD_WID),
    .AWID  (WORD_AMNT_WID)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (r_windex),
    .wr_data (w_wr_data),
    .rd_en   (w_rd_en),
    .rd_addr (r_ptr),
    .rd_data (w_rd_data)
  );

  assign bus.word             = r_word;
  assign bus.word_ok          = r_word_ok;
  assign bus.word_last        = r_word_last;
  assign bus.refresh_finished = r_finished;
  assign bus.ram_dma_addr     = r_addr;
  assign bus.ram_read         = r_ram_read;
endmodule
`default_nettype wire

// File: tb/tb_waveform_word_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_waveform_word_buffer : directed self-checking bench with a DMA RAM model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_waveform_word_buffer;
  localparam int WW   = 20;
  localparam int AW   = 11;
  localparam int AMNT = 4;
  localparam int RW   = 32;
  localparam int RWW  = 16;
  localparam int INCR = 2;

  logic clk;
  logic rst_L;

  waveform_word_buffer_if #(.WORD_WID(WW), .RAM_WID(RW), .RAM_WORD_WID(RWW)) bus ();

  waveform_word_buffer #(
    .WORD_WID      (WW),
    .WORD_AMNT_WID (AW),
    .WORD_AMNT     (AMNT),
    .RAM_WID       (RW),
    .RAM_WORD_WID  (RWW),
    .RAM_WORD_INCR (INCR)
  ) dut (
    .clk   (clk),
    .rst_L (rst_L),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // DMA RAM model: data = low 16 address bits, valid after rsp_delay cycles.
  int          rsp_delay  = 0;
  int          read_count = 0;
  int          addr_err   = 0;
  int          gap_err    = 0;
  int          wait_cnt   = 0;
  int          idle_run   = 0;
  bit          prev_read  = 1'b0;
  bit          started    = 1'b0;
  logic [31:0] req_addr   = '0;
  logic [31:0] addr_q[$];

  initial begin
    bus.ram_valid = 1'b0;
    bus.ram_word  = '0;
    forever begin
      @(negedge clk);
      if (bus.ram_read) begin
        if (!prev_read) begin
          if (started && idle_run != 1) gap_err++;
          started  = 1'b1;
          req_addr = bus.ram_dma_addr;
          wait_cnt = 0;
        end else if (bus.ram_dma_addr !== req_addr) begin
          addr_err++;
        end
        idle_run = 0;
        if (wait_cnt == rsp_delay) begin
          bus.ram_valid = 1'b1;
          bus.ram_word  = bus.ram_dma_addr[15:0];
          read_count++;
          addr_q.push_back(bus.ram_dma_addr);
        end else begin
          bus.ram_valid = 1'b0;
        end
        wait_cnt++;
      end else begin
        bus.ram_valid = 1'b0;
        idle_run++;
      end
      prev_read = bus.ram_read;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_model(input int delay);
    rsp_delay  = delay;
    read_count = 0;
    addr_err   = 0;
    gap_err    = 0;
    started    = 1'b0;
    addr_q.delete();
  endtask

  task automatic do_refresh(input logic [31:0] start, input int delay);
    int waited;
    int bad;
    clear_model(delay);
    bus.start_addr    = start;
    bus.word_rst      = 1'b1;
    bus.refresh_start = 1'b1;
    waited = 0;
    while (!bus.refresh_finished && waited < 2000) begin
      tick();
      waited++;
    end
    check("refresh_finished_rise", {31'd0, bus.refresh_finished}, 32'd1);
    check("read_count", read_count, 2 * AMNT);
    bad = 0;
    for (int i = 0; i < addr_q.size(); i++) begin
      if (addr_q[i] !== start + 32'(INCR * i)) bad++;
    end
    check("addr_sequence_bad", bad, 0);
    check("addr_stable_err", addr_err, 0);
    check("gap_err", gap_err, 0);
    tick();
    check("refresh_finished_held", {31'd0, bus.refresh_finished}, 32'd1);
    bus.refresh_start = 1'b0;
    tick();
    check("refresh_finished_drop", {31'd0, bus.refresh_finished}, 32'd0);
    bus.word_rst = 1'b0;
    tick();
  endtask

  task automatic request(input string tag, input logic [19:0] exp_word, input bit exp_last);
    int lat;
    bus.word_next = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.word_ok && lat < 20);
    check({tag, "_latency"}, lat, 2);
    check({tag, "_word"}, {12'd0, bus.word}, {12'd0, exp_word});
    check({tag, "_last"}, {31'd0, bus.word_last}, {31'd0, exp_last});
    tick();
    check({tag, "_held"}, {12'd0, bus.word}, {12'd0, exp_word});
    bus.word_next = 1'b0;
    tick();
    check({tag, "_ok_drop"}, {31'd0, bus.word_ok}, 32'd0);
  endtask

  task automatic pulse_word_rst();
    bus.word_rst = 1'b1;
    tick();
    bus.word_rst = 1'b0;
    tick();
  endtask

  logic [19:0] exp_words[AMNT];

  initial begin
    int waited;
    exp_words[0] = 20'h21000;
    exp_words[1] = 20'h61004;
    exp_words[2] = 20'hA1008;
    exp_words[3] = 20'hE100C;

    rst_L             = 1'b0;
    bus.word_rst      = 1'b0;
    bus.word_next     = 1'b0;
    bus.refresh_start = 1'b0;
    bus.start_addr    = '0;
    repeat (3) tick();
    check("rst_word", {12'd0, bus.word}, 32'd0);
    check("rst_word_ok", {31'd0, bus.word_ok}, 32'd0);
    check("rst_word_last", {31'd0, bus.word_last}, 32'd0);
    check("rst_refresh_finished", {31'd0, bus.refresh_finished}, 32'd0);
    check("rst_ram_dma_addr", bus.ram_dma_addr, 32'd0);
    check("rst_ram_read", {31'd0, bus.ram_read}, 32'd0);
    rst_L = 1'b1;
    tick();

    // Baseline refresh and wrapping readout
    do_refresh(32'h1000, 0);
    for (int i = 0; i < 6; i++) begin
      request($sformatf("rd%0d", i), exp_words[i % AMNT], (i % AMNT) == AMNT - 1);
    end

    // word_rst rewinds the pointer
    pulse_word_rst();
    for (int i = 0; i < 3; i++) request($sformatf("rw%0d", i), exp_words[i], 1'b0);
    pulse_word_rst();
    request("rw_after", exp_words[0], 1'b0);

    // refresh_start ignored without word_rst
    clear_model(0);
    bus.start_addr    = 32'h2000;
    bus.word_rst      = 1'b0;
    bus.refresh_start = 1'b1;
    repeat (10) tick();
    check("ignored_reads", read_count, 0);
    check("ignored_ram_read", {31'd0, bus.ram_read}, 32'd0);
    check("ignored_finished", {31'd0, bus.refresh_finished}, 32'd0);
    do_refresh(32'h2000, 0);
    request("alt0", 20'h22000, 1'b0);
    request("alt1", 20'h62004, 1'b0);

    // Slow RAM: same contents as the baseline
    do_refresh(32'h1000, 5);
    pulse_word_rst();
    for (int i = 0; i < AMNT; i++) begin
      request($sformatf("slow%0d", i), exp_words[i], i == AMNT - 1);
    end

    // Reset in the middle of a refresh
    clear_model(0);
    bus.start_addr    = 32'h1000;
    bus.word_rst      = 1'b1;
    bus.refresh_start = 1'b1;
    waited = 0;
    while (read_count < 3 && waited < 200) begin
      tick();
      waited++;
    end
    check("midrst_reads_seen", read_count, 3);
    rst_L             = 1'b0;
    bus.refresh_start = 1'b0;
    tick();
    check("midrst_ram_read", {31'd0, bus.ram_read}, 32'd0);
    check("midrst_dma_addr", bus.ram_dma_addr, 32'd0);
    check("midrst_finished", {31'd0, bus.refresh_finished}, 32'd0);
    check("midrst_word_ok", {31'd0, bus.word_ok}, 32'd0);
    tick();
    rst_L = 1'b1;
    tick();
    check("midrst_idle_reads", read_count, 3);
    do_refresh(32'h1000, 0);
    request("post_rst0", exp_words[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
